// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger
//   Self-triggering driver for a single-pin (PING-style) ultrasonic sensor.
//   Pulses the shared Sig line, times the returning echo, and maps the echo
//   width onto an N_LEDS distance display. TIME/VALID/TIMEOUT are exported
//   for other consumers.
//
// Ports
//   CLK      in     system clock, rising edge
//   RESET    in     synchronous reset, active-low
//   Sig      inout  sensor line; driven high only while triggering, else Z
//   LED      out    distance display (one-hot, or thermometer when built with
//                   ULTRASONIC_BAR_GRAPH_EN)
//   TIME     out    last echo width in CLK cycles (MAX_CYC on timeout)
//   VALID    out    one-cycle pulse when TIME/TIMEOUT update
//   TIMEOUT  out    last measurement had no echo or saturated
//
// Configuration macro: ULTRASONIC_BAR_GRAPH_EN selects thermometer LED code.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | Sig released, wait for sig_s low (waits out stuck-high line)
// TRIG      | drive Sig high for TRIG_CYC cycles
// HOLDOFF   | Sig released, sig_s ignored for HOLDOFF_CYC cycles
// WAIT_RISE | wait up to ECHO_WAIT_CYC cycles for echo rising edge
// MEASURE   | count echo high cycles, saturate at MAX_CYC
// DONE      | one cycle, VALID high with fresh TIME/TIMEOUT
// GAP       | REPEAT_CYC idle cycles before the next trigger
module ultrasonic_ranger #(
  parameter int N_LEDS        = 8,
  parameter int CNT_W         = 20,
  parameter int BIN_CYC       = 10000,
  parameter int TRIG_CYC      = 1000,
  parameter int HOLDOFF_CYC   = 75000,
  parameter int ECHO_WAIT_CYC = 100000,
  parameter int MAX_CYC       = (1 << CNT_W) - 1,
  parameter int REPEAT_CYC    = 500000
) (
  input  logic              CLK,
  input  logic              RESET,
  inout  wire               Sig,
  output logic [N_LEDS-1:0] LED,
  output logic [CNT_W-1:0]  TIME,
  output logic              VALID,
  output logic              TIMEOUT
);

  localparam int BIN_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  // Timer reload values: a state with a reload of X-1 lasts exactly X cycles.
  localparam logic [CNT_W-1:0] TRIG_LD    = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD    = CNT_W'(ECHO_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_V      = CNT_W'(MAX_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_HOLDOFF,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sig_m_q, sig_s_q;
  logic               sig_oe_q;
  logic [CNT_W-1:0]   time_q;
  logic               timeout_q;
  logic               valid_q;
  logic [N_LEDS-1:0]  led_q, led_d;
  logic [BIN_W-1:0]   bin;

  logic               pub;
  logic               pub_to;
  logic [CNT_W-1:0]   pub_time;

  assign Sig     = sig_oe_q ? 1'b1 : 1'bz;
  assign LED     = led_q;
  assign TIME    = time_q;
  assign VALID   = valid_q;
  assign TIMEOUT = timeout_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pub      = 1'b0;
    pub_to   = 1'b0;
    pub_time = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (!sig_s_q) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (tmr_q == '0) state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (tmr_q == '0) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (sig_s_q) begin
          // The first high cycle is already part of the echo width.
          state_d = S_MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (tmr_q == '0) begin
          state_d  = S_DONE;
          pub      = 1'b1;
          pub_to   = 1'b1;
          pub_time = MAX_V;
        end
      end
      S_MEASURE: begin
        if (!sig_s_q) begin
          state_d  = S_DONE;
          pub      = 1'b1;
          pub_time = cnt_q;
        end else if (cnt_q >= MAX_V - CNT_W'(1)) begin
          // This high cycle would bring the count to MAX_CYC: saturate.
          state_d  = S_DONE;
          pub      = 1'b1;
          pub_to   = 1'b1;
          pub_time = MAX_V;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_GAP;
      end
      S_GAP: begin
        if (tmr_q == '0) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    tmr_d = (tmr_q != '0) ? tmr_q - CNT_W'(1) : tmr_q;
    if (state_d != state_q) begin
      case (state_d)
        S_TRIG:      tmr_d = TRIG_LD;
        S_HOLDOFF:   tmr_d = HOLDOFF_LD;
        S_WAIT_RISE: tmr_d = WAIT_LD;
        S_GAP:       tmr_d = GAP_LD;
        default:     tmr_d = '0;
      endcase
    end
  end

  // Distance bin as a compare chain: bin k-1 covers ((k-1)*BIN_CYC, k*BIN_CYC].
  always_comb begin
    bin = '0;
    for (int k = 1; k < N_LEDS; k++) begin
      if (64'(time_q) > 64'(k) * 64'(BIN_CYC)) bin = bin + BIN_W'(1);
    end
    if (timeout_q) bin = BIN_W'(N_LEDS - 1);
  end

`ifdef ULTRASONIC_BAR_GRAPH_EN
  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      led_d[i] = (i <= int'(bin));
    end
  end
`else
  always_comb begin
    led_d = N_LEDS'(1) << bin;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      sig_m_q   <= 1'b0;
      sig_s_q   <= 1'b0;
      sig_oe_q  <= 1'b0;
      time_q    <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      led_q     <= N_LEDS'(1);
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      sig_m_q  <= Sig;
      sig_s_q  <= sig_m_q;
      sig_oe_q <= (state_d == S_TRIG);
      valid_q  <= pub;
      if (pub) begin
        time_q    <= pub_time;
        timeout_q <= pub_to;
      end
      // LED follows the freshly published result one cycle after VALID.
      if (valid_q) led_q <= led_d;
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
module tb_ultrasonic_ranger;

  localparam int N_LEDS        = 8;
  localparam int CNT_W         = 20;
  localparam int BIN_CYC       = 100;
  localparam int TRIG_CYC      = 5;
  localparam int HOLDOFF_CYC   = 10;
  localparam int ECHO_WAIT_CYC = 200;
  localparam int MAX_CYC       = 1000;
  localparam int REPEAT_CYC    = 50;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              sens_en = 1'b0;
  wire               Sig;
  wire [N_LEDS-1:0]  LED;
  wire [CNT_W-1:0]   TIME;
  wire               VALID;
  wire               TIMEOUT;

  int total = 0;
  int bad   = 0;
  bit abort = 1'b0;

  // Sensor model: drives the line high while echoing, otherwise releases it.
  assign Sig = sens_en ? 1'b1 : 1'bz;
  pulldown (Sig);

  ultrasonic_ranger #(
    .N_LEDS(N_LEDS), .CNT_W(CNT_W), .BIN_CYC(BIN_CYC), .TRIG_CYC(TRIG_CYC),
    .HOLDOFF_CYC(HOLDOFF_CYC), .ECHO_WAIT_CYC(ECHO_WAIT_CYC),
    .MAX_CYC(MAX_CYC), .REPEAT_CYC(REPEAT_CYC)
  ) dut (
    .CLK(CLK), .RESET(RESET), .Sig(Sig), .LED(LED),
    .TIME(TIME), .VALID(VALID), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: echo length L (0 = no echo) -> published result.
  function automatic bit exp_to(input int L);
    return (L == 0) || (L >= MAX_CYC);
  endfunction

  function automatic int exp_time(input int L);
    return exp_to(L) ? MAX_CYC : L;
  endfunction

  function automatic logic [N_LEDS-1:0] exp_led(input int L);
    int b;
    if (exp_to(L)) b = N_LEDS - 1;
    else begin
      b = (L - 1) / BIN_CYC;
      if (b > N_LEDS - 1) b = N_LEDS - 1;
    end
`ifdef ULTRASONIC_BAR_GRAPH_EN
    return N_LEDS'((1 << (b + 1)) - 1);
`else
    return N_LEDS'(1 << b);
`endif
  endfunction

  // Called on the negedge where the trigger is first seen high.
  task automatic count_trig(input string name);
    int n = 0;
    while (Sig === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk({name, ":trig_len"}, n, TRIG_CYC);
  endtask

  // Starts on the negedge right after a trigger released Sig (t=0).
  task automatic run_meas(input string name, input int d, input int L,
                          input int g0, input int gl);
    int tv = -1;
    int nv = 0;
    int ttrig = -1;
    logic [CNT_W-1:0]  tim = '0;
    logic              to = 1'b0;
    logic [N_LEDS-1:0] led = '0;
    if (abort) return;
    sens_en = 1'b0;
    for (int t = 1; t <= 20000; t++) begin
      @(negedge CLK);
      if (VALID === 1'b1) begin
        nv++;
        if (tv < 0) begin
          tv  = t;
          tim = TIME;
          to  = TIMEOUT;
        end
      end
      if (tv >= 0 && t == tv + 1) led = LED;
      if (Sig === 1'b1 && !sens_en) begin
        ttrig = t;
        break;
      end
      sens_en = (gl > 0 && t >= g0 && t < g0 + gl) || (L > 0 && t >= d && t < d + L);
    end
    sens_en = 1'b0;
    chk({name, ":valid_seen"}, (tv >= 0), 1);
    chk({name, ":valid_pulses"}, nv, 1);
    if (tv >= 0) begin
      chk({name, ":time"}, tim, exp_time(L));
      chk({name, ":timeout"}, to, exp_to(L));
      chk({name, ":led"}, led, exp_led(L));
    end
    if (L == 0) chk({name, ":timeout_latency"}, tv, HOLDOFF_CYC + ECHO_WAIT_CYC);
    if (L >= MAX_CYC) begin
      chk({name, ":sat_during_echo"}, (tv >= 0 && tv < d + L), 1);
      chk({name, ":retrig_after_release"}, (ttrig >= d + L), 1);
    end
    chk({name, ":retrig_seen"}, (ttrig >= 0), 1);
    if (ttrig < 0) begin
      abort = 1'b1;
      return;
    end
    chk({name, ":gap"}, ((ttrig - tv) >= REPEAT_CYC), 1);
    count_trig(name);
  endtask

  initial begin
    int d, L;
    // Power-up reset, then reset again in the middle of the first trigger.
    RESET = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rst:sig", Sig, 0);
    chk("rst:led", LED, 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("first_trig_start", Sig, 1);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("midrst:sig_released", Sig, 0);
    chk("midrst:time", TIME, 0);
    chk("midrst:valid", VALID, 0);
    chk("midrst:timeout", TIMEOUT, 0);
    chk("midrst:led", LED, 1);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("retrig_after_reset", Sig, 1);
    count_trig("post_reset");

    run_meas("echo350",  15, 350,  0, 0);
    run_meas("echo100",  20, 100,  0, 0);
    run_meas("echo101",  20, 101,  0, 0);
    run_meas("noecho",    0,   0,  0, 0);
    run_meas("echo5000", 12, 5000, 0, 0);
    run_meas("glitch250", 20, 250, 1, 3);
    run_meas("echo1",    30,   1,  0, 0);
    run_meas("echo999",  14, 999,  0, 0);
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(12, 60);
      L = $urandom_range(1, 999);
      if (i % 2 == 1) run_meas("rand_glitch", d, L, 1, $urandom_range(1, 4));
      else run_meas("rand", d, L, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
